div24u_12u_seq: RTL and testbench



---
 rtl/div24u_12u_seq.sv | 145 ++++++++++++++
 tb/tb_div24u_12u_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div24u_12u_seq.sv
// Sequential radix-2 restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor.
// One quotient bit per clock, valid/ready handshake on both sides.
module div24u_12u_seq #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);

  if ((2 ** CNT_W) <= WIDTH) begin : gen_cnt_check
    $error("CNT_W too small to count WIDTH iterations");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     rem_q, rem_d;
  // Low dividend bits shift out the top while quotient bits shift in at the bottom.
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rmd_q, rmd_d;
  logic               dz_q, dz_d;
  logic               ov_q, ov_d;

  logic [WIDTH-1:0]   dividend_hi;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     divisor_ext;
  logic [WIDTH:0]     trial_sub;
  logic [WIDTH:0]     rem_next;
  logic               trial_ge;
  logic               last_iter;
  logic               unused_rem_msb;

  assign dividend_hi = dividend[2*WIDTH-1:WIDTH];
  assign divisor_ext = {1'b0, div_q};
  assign trial       = {rem_q[WIDTH-1:0], shift_q[WIDTH-1]};
  assign trial_ge    = (trial >= divisor_ext);
  assign trial_sub   = trial - divisor_ext;
  assign rem_next    = trial_ge ? trial_sub : trial;
  assign last_iter   = (cnt_q == CNT_W'(WIDTH - 1));

  // Partial remainder stays below the divisor, so its top bit is always zero.
  assign unused_rem_msb = rem_q[WIDTH];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    shift_d = shift_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dz_d    = dz_q;
    ov_d    = ov_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          div_d = divisor;
          if (divisor == '0) begin
            state_d = StDone;
            quo_d   = '1;
            rmd_d   = '0;
            dz_d    = 1'b1;
            ov_d    = 1'b0;
          end else if (dividend_hi >= divisor) begin
            state_d = StDone;
            quo_d   = '1;
            rmd_d   = '0;
            dz_d    = 1'b0;
            ov_d    = 1'b1;
          end else begin
            state_d = StCalc;
            rem_d   = {1'b0, dividend_hi};
            shift_d = dividend[WIDTH-1:0];
            cnt_d   = '0;
            dz_d    = 1'b0;
            ov_d    = 1'b0;
          end
        end
      end
      StCalc: begin
        rem_d   = rem_next;
        shift_d = {shift_q[WIDTH-2:0], trial_ge};
        cnt_d   = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = StDone;
          quo_d   = {shift_q[WIDTH-2:0], trial_ge};
          rmd_d   = rem_next[WIDTH-1:0];
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      shift_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign div_zero  = dz_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_div24u_12u_seq.sv
// Directed and randomised bench for div24u_12u_seq with hand-computed expectations.
module tb_div24u_12u_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] dividend;
  logic [11:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] quotient;
  logic [11:0] remainder;
  logic        div_zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div24u_12u_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for the result, capture it and complete the handshake.
  task automatic run_op(input logic [23:0] n, input logic [11:0] d, output int lat,
                        output logic [11:0] q, output logic [11:0] r,
                        output logic dz, output logic ov);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    dividend = n;
    divisor  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    dividend = 24'hABCDEF;
    divisor  = 12'h5A5;
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_zero;
    ov = overflow;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    dividend  = 24'h003039;
    divisor   = 12'h007;
    step();
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    checks++;
    if (quotient !== 12'h000 || remainder !== 12'h000) begin
      errors++;
      $display("FAIL reset_data got q=%h r=%h want 000 000", quotient, remainder);
    end
    checks++;
    if (div_zero !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got dz=%b ov=%b want 0 0", div_zero, overflow);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    step();
  endtask

  task automatic test_exact();
    int lat;
    logic [11:0] q, r;
    logic dz, ov;
    run_op(24'h0F4240, 12'h3E8, lat, q, r, dz, ov);
    checks++;
    if (q !== 12'h3E8 || r !== 12'h000) begin
      errors++;
      $display("FAIL exact_qr got q=%h r=%h want 3e8 000", q, r);
    end
    checks++;
    if (dz !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL exact_flags got dz=%b ov=%b want 0 0", dz, ov);
    end
    checks++;
    if (lat != 13) begin
      errors++;
      $display("FAIL exact_latency got %0d want 13", lat);
    end
  endtask

  task automatic test_nonexact();
    int lat;
    logic [11:0] q, r;
    logic dz, ov;
    run_op(24'h003039, 12'h007, lat, q, r, dz, ov);
    checks++;
    if (q !== 12'h6E3 || r !== 12'h004 || dz !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL nonexact got q=%h r=%h dz=%b ov=%b want 6e3 004 0 0", q, r, dz, ov);
    end
  endtask

  task automatic test_boundary();
    int lat;
    logic [11:0] q, r;
    logic dz, ov;
    run_op(24'hFFE001, 12'hFFF, lat, q, r, dz, ov);
    checks++;
    if (q !== 12'hFFF || r !== 12'h000 || ov !== 1'b0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL boundary got q=%h r=%h dz=%b ov=%b want fff 000 0 0", q, r, dz, ov);
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [11:0] q, r;
    logic dz, ov;
    run_op(24'h100000, 12'h100, lat, q, r, dz, ov);
    checks++;
    if (q !== 12'hFFF || r !== 12'h000 || ov !== 1'b1 || dz !== 1'b0) begin
      errors++;
      $display("FAIL overflow got q=%h r=%h dz=%b ov=%b want fff 000 0 1", q, r, dz, ov);
    end
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL overflow_latency got %0d want 1", lat);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [11:0] q, r;
    logic dz, ov;
    run_op(24'h001234, 12'h000, lat, q, r, dz, ov);
    checks++;
    if (q !== 12'hFFF || r !== 12'h000 || ov !== 1'b0 || dz !== 1'b1) begin
      errors++;
      $display("FAIL div_zero got q=%h r=%h dz=%b ov=%b want fff 000 1 0", q, r, dz, ov);
    end
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL div_zero_latency got %0d want 1", lat);
    end
  endtask

  task automatic test_backpressure();
    int guard;
    dividend = 24'h003039;
    divisor  = 12'h007;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      step();
      guard++;
    end
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      dividend = 24'h000100 + 24'(i);
      divisor  = 12'h001;
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 12'h6E3 ||
          remainder !== 12'h004 || div_zero !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got ov_valid=%b rdy=%b q=%h r=%h want 1 0 6e3 004",
                 i, out_valid, in_ready, quotient, remainder);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_release_idle got out_valid=%b in_ready=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    logic [11:0] q, r;
    logic dz, ov;
    logic seen;
    dividend = 24'h0F4240;
    divisor  = 12'h3E8;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_result got out_valid seen=%b want 0", seen);
    end
    run_op(24'h003039, 12'h007, lat, q, r, dz, ov);
    checks++;
    if (q !== 12'h6E3 || r !== 12'h004 || lat != 13) begin
      errors++;
      $display("FAIL after_abort got q=%h r=%h lat=%0d want 6e3 004 13", q, r, lat);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    t1 = 0;
    t2 = 0;
    dividend  = 24'h003039;
    divisor   = 12'h007;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 60 && t2 == 0; c++) begin
      step();
      if (out_valid) begin
        if (t1 == 0) t1 = c;
        else t2 = c;
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    checks++;
    if (t1 != 13 || t2 - t1 != 14) begin
      errors++;
      $display("FAIL back_to_back got first=%0d spacing=%0d want 13 14", t1, t2 - t1);
    end
  endtask

  task automatic test_random();
    logic [23:0] n;
    logic [11:0] d, hi, lo, q, r;
    logic dz, ov, got, done, hs;
    int unsigned exp_q, exp_r;
    int guard;
    for (int k = 0; k < 2000; k++) begin
      d  = 12'($urandom_range(1, 4095));
      hi = 12'($urandom_range(0, int'(d) - 1));
      lo = 12'($urandom_range(0, 4095));
      n  = {hi, lo};
      exp_q = 32'(n) / 32'(d);
      exp_r = 32'(n) % 32'(d);
      in_valid  = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      for (int w = $urandom_range(0, 2); w > 0; w--) step();
      guard = 0;
      while (!in_ready && guard < 50) begin
        step();
        guard++;
      end
      dividend = n;
      divisor  = d;
      in_valid = 1'b1;
      step();
      got  = 1'b0;
      done = 1'b0;
      q = '0; r = '0; dz = 1'b1; ov = 1'b1;
      guard = 0;
      while (!done && guard < 200) begin
        in_valid  = 1'($urandom_range(0, 1));
        dividend  = 24'($urandom);
        divisor   = 12'($urandom);
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && !got) begin
          q = quotient; r = remainder; dz = div_zero; ov = overflow;
          got = 1'b1;
        end
        hs = out_valid && out_ready;
        step();
        guard++;
        if (hs) done = 1'b1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (!got || 32'(q) != exp_q || 32'(r) != exp_r || dz !== 1'b0 || ov !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d n=%h d=%h got q=%h r=%h dz=%b ov=%b want q=%h r=%h",
                 k, n, d, q, r, dz, ov, exp_q[11:0], exp_r[11:0]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_exact();
    test_nonexact();
    test_boundary();
    test_overflow();
    test_div_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
